// File: rtl/riscv_tpr_update_ctrl.sv
// Tag Propagation Register update sequencer: buffers CSR writes in a shadow
// register and commits them to the ID-stage TPR only once no store is in flight.
module riscv_tpr_update_ctrl #(
    parameter int unsigned OUTST_W = 2,
    parameter logic [31:0] TPR_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tpr_we_i,
    input  logic [31:0] tpr_wdata_i,
    input  logic        is_store_id_i,
    input  logic        store_issue_i,
    input  logic        store_done_i,
    output logic [31:0] tpr_o,
    output logic [31:0] tpr_rdata_o,
    output logic        stall_store_o,
    output logic        update_pending_o,
    output logic        proto_err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        DRAIN  = 2'b01,
        COMMIT = 2'b10
    } state_t;

    localparam logic [OUTST_W-1:0] CNT_ZERO = {OUTST_W{1'b0}};
    localparam logic [OUTST_W-1:0] CNT_MAX  = {OUTST_W{1'b1}};
    localparam logic [OUTST_W-1:0] CNT_ONE  = OUTST_W'(1'b1);

    state_t             state_r;
    state_t             state_next_s;
    logic [OUTST_W-1:0] cnt_r;
    logic [OUTST_W-1:0] cnt_next_s;
    logic [31:0]        shadow_r;
    logic [31:0]        shadow_next_s;
    logic [31:0]        tpr_r;
    logic [31:0]        tpr_next_s;
    logic               proto_err_r;
    logic               proto_set_s;
    logic               stall_s;

    // Outstanding-store count; saturates at both ends instead of wrapping.
    always_comb begin
        cnt_next_s = cnt_r;
        if (store_issue_i && !store_done_i) begin
            if (cnt_r == CNT_MAX) begin
                cnt_next_s = CNT_MAX;
            end else begin
                cnt_next_s = cnt_r + CNT_ONE;
            end
        end else if (store_done_i && !store_issue_i) begin
            if (cnt_r == CNT_ZERO) begin
                cnt_next_s = CNT_ZERO;
            end else begin
                cnt_next_s = cnt_r - CNT_ONE;
            end
        end else begin
            cnt_next_s = cnt_r;
        end
    end

    assign stall_s = is_store_id_i & ((state_r != IDLE) | (cnt_r == CNT_MAX));

    assign proto_set_s = (store_issue_i & stall_s)
                       | (store_done_i & (cnt_r == CNT_ZERO))
                       | (store_issue_i & ~store_done_i & (cnt_r == CNT_MAX));

    // Update sequencer; a write landing in COMMIT is folded straight into the commit.
    always_comb begin
        state_next_s  = state_r;
        shadow_next_s = shadow_r;
        tpr_next_s    = tpr_r;
        case (state_r)
            IDLE: begin
                if (tpr_we_i) begin
                    shadow_next_s = tpr_wdata_i;
                    if (cnt_next_s == CNT_ZERO) begin
                        state_next_s = COMMIT;
                    end else begin
                        state_next_s = DRAIN;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            DRAIN: begin
                if (tpr_we_i) begin
                    shadow_next_s = tpr_wdata_i;
                end else begin
                    shadow_next_s = shadow_r;
                end
                if (cnt_next_s == CNT_ZERO) begin
                    state_next_s = COMMIT;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            COMMIT: begin
                if (tpr_we_i) begin
                    tpr_next_s = tpr_wdata_i;
                end else begin
                    tpr_next_s = shadow_r;
                end
                shadow_next_s = tpr_next_s;
                state_next_s  = IDLE;
            end
            default: begin
                state_next_s  = IDLE;
                shadow_next_s = tpr_r;
                tpr_next_s    = tpr_r;
            end
        endcase
    end

    // State, counter, TPR copies and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            shadow_r    <= TPR_RST;
            tpr_r       <= TPR_RST;
            proto_err_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            cnt_r       <= cnt_next_s;
            shadow_r    <= shadow_next_s;
            tpr_r       <= tpr_next_s;
            proto_err_r <= proto_err_r | proto_set_s;
        end
    end

    assign tpr_o            = tpr_r;
    assign update_pending_o = (state_r != IDLE);
    assign tpr_rdata_o      = update_pending_o ? shadow_r : tpr_r;
    assign stall_store_o    = stall_s;
    assign proto_err_o      = proto_err_r;

endmodule

// File: tb/tb_riscv_tpr_update_ctrl.sv
// Directed bench for riscv_tpr_update_ctrl with hand-computed expectations.
module tb_riscv_tpr_update_ctrl;

    logic        clk;
    logic        rst_n;
    logic        tpr_we_i;
    logic [31:0] tpr_wdata_i;
    logic        is_store_id_i;
    logic        store_issue_i;
    logic        store_done_i;
    logic [31:0] tpr_o;
    logic [31:0] tpr_rdata_o;
    logic        stall_store_o;
    logic        update_pending_o;
    logic        proto_err_o;

    int n_chk  = 0;
    int n_fail = 0;

    riscv_tpr_update_ctrl #(
        .OUTST_W (2),
        .TPR_RST (32'h0000_0000)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .tpr_we_i         (tpr_we_i),
        .tpr_wdata_i      (tpr_wdata_i),
        .is_store_id_i    (is_store_id_i),
        .store_issue_i    (store_issue_i),
        .store_done_i     (store_done_i),
        .tpr_o            (tpr_o),
        .tpr_rdata_o      (tpr_rdata_o),
        .stall_store_o    (stall_store_o),
        .update_pending_o (update_pending_o),
        .proto_err_o      (proto_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: apply strobes, cross the edge, clear strobes, settle.
    task automatic cyc(input logic we, input logic [31:0] wd, input logic iss, input logic dn);
        tpr_we_i      = we;
        tpr_wdata_i   = wd;
        store_issue_i = iss;
        store_done_i  = dn;
        @(posedge clk);
        #1;
        tpr_we_i      = 1'b0;
        tpr_wdata_i   = 32'h0;
        store_issue_i = 1'b0;
        store_done_i  = 1'b0;
        #1;
    endtask

    initial begin
        rst_n = 1'b0; tpr_we_i = 1'b0; tpr_wdata_i = 32'h0;
        is_store_id_i = 1'b0; store_issue_i = 1'b0; store_done_i = 1'b0;
        #2;
        check_eq("rst_tpr",     tpr_o,            32'h0);
        check_eq("rst_rdata",   tpr_rdata_o,      32'h0);
        check_eq("rst_pending", {31'h0, update_pending_o}, 32'h0);
        check_eq("rst_perr",    {31'h0, proto_err_o},      32'h0);
        is_store_id_i = 1'b1; #1;
        check_eq("rst_stall",   {31'h0, stall_store_o},    32'h0);
        is_store_id_i = 1'b0;
        #9 rst_n = 1'b1;
        @(posedge clk); #2;

        // Idle write with nothing in flight
        cyc(1'b1, 32'h0000_0F00, 1'b0, 1'b0);
        check_eq("t1_c1_rdata",   tpr_rdata_o,      32'h0000_0F00);
        check_eq("t1_c1_tpr",     tpr_o,            32'h0);
        check_eq("t1_c1_pending", {31'h0, update_pending_o}, 32'h1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("t1_c2_tpr",     tpr_o,            32'h0000_0F00);
        check_eq("t1_c2_pending", {31'h0, update_pending_o}, 32'h0);

        // Drain with two stores in flight
        is_store_id_i = 1'b1;
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("t2_stall_cnt2", {31'h0, stall_store_o}, 32'h0);
        cyc(1'b1, 32'hA5A5_0000, 1'b0, 1'b0);                 // cycle 1
        check_eq("t2_c1_stall",   {31'h0, stall_store_o}, 32'h1);
        check_eq("t2_c1_tpr",     tpr_o,            32'h0000_0F00);
        check_eq("t2_c1_rdata",   tpr_rdata_o,      32'hA5A5_0000);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);                         // cycle 2
        cyc(1'b0, 32'h0, 1'b0, 1'b0);                         // cycle 3
        cyc(1'b0, 32'h0, 1'b0, 1'b1);                         // done in 3
        cyc(1'b0, 32'h0, 1'b0, 1'b0);                         // cycle 5
        cyc(1'b0, 32'h0, 1'b0, 1'b0);                         // cycle 6
        check_eq("t2_c6_tpr",     tpr_o,            32'h0000_0F00);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);                         // done in 6 -> cycle 7
        check_eq("t2_c7_pending", {31'h0, update_pending_o}, 32'h1);
        check_eq("t2_c7_stall",   {31'h0, stall_store_o},    32'h1);
        check_eq("t2_c7_tpr",     tpr_o,            32'h0000_0F00);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);                         // cycle 8
        check_eq("t2_c8_tpr",     tpr_o,            32'hA5A5_0000);
        check_eq("t2_c8_stall",   {31'h0, stall_store_o},    32'h0);

        // Back-to-back writes while draining one store
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        is_store_id_i = 1'b0;
        cyc(1'b1, 32'h1, 1'b0, 1'b0);
        check_eq("t3_rd1",  tpr_rdata_o, 32'h1);
        check_eq("t3_tpr1", tpr_o,       32'hA5A5_0000);
        cyc(1'b1, 32'h2, 1'b0, 1'b0);
        check_eq("t3_rd2",  tpr_rdata_o, 32'h2);
        check_eq("t3_tpr2", tpr_o,       32'hA5A5_0000);
        cyc(1'b1, 32'h3, 1'b0, 1'b0);
        check_eq("t3_rd3",  tpr_rdata_o, 32'h3);
        check_eq("t3_tpr3", tpr_o,       32'hA5A5_0000);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("t3_commit_tpr", tpr_o, 32'hA5A5_0000);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("t3_final_tpr",  tpr_o, 32'h3);

        // Simultaneous issue and done at cnt=1 keeps draining
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h55, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("t4_pending", {31'h0, update_pending_o}, 32'h1);
        check_eq("t4_tpr",     tpr_o, 32'h3);
        check_eq("t4_perr0",   {31'h0, proto_err_o}, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("t4_commit",  {31'h0, update_pending_o}, 32'h1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("t4_tpr55",   tpr_o, 32'h55);
        check_eq("t4_idle",    {31'h0, update_pending_o}, 32'h0);

        // Issue while stalled raises the sticky error
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h66, 1'b0, 1'b0);
        is_store_id_i = 1'b1;
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        is_store_id_i = 1'b0;
        check_eq("t4_perr1",   {31'h0, proto_err_o}, 32'h1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("t4_still_drain", {31'h0, update_pending_o}, 32'h1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("t4_tpr66",   tpr_o, 32'h66);
        check_eq("t4_perr_hold", {31'h0, proto_err_o}, 32'h1);

        // Asynchronous reset mid-drain discards the shadow value
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b1, 32'h1234, 1'b0, 1'b0);
        check_eq("t6_rd_shadow", tpr_rdata_o, 32'h1234);
        #1 rst_n = 1'b0;
        #1;
        check_eq("t6_tpr_rst",  tpr_o, 32'h0);
        check_eq("t6_pend_rst", {31'h0, update_pending_o}, 32'h0);
        check_eq("t6_perr_rst", {31'h0, proto_err_o}, 32'h0);
        check_eq("t6_rd_rst",   tpr_rdata_o, 32'h0);
        #2 rst_n = 1'b1;
        @(posedge clk); #2;
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("t6_tpr_after", tpr_o, 32'h0);
        check_eq("t6_pend_after", {31'h0, update_pending_o}, 32'h0);

        // Saturation and done-at-zero
        is_store_id_i = 1'b1;
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        cyc(1'b0, 32'h0, 1'b1, 1'b0);
        check_eq("t5_stall_max", {31'h0, stall_store_o}, 32'h1);
        check_eq("t5_perr0",     {31'h0, proto_err_o},   32'h0);
        is_store_id_i = 1'b0; #1;
        check_eq("t5_nonstore",  {31'h0, stall_store_o}, 32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("t5_perr_zero", {31'h0, proto_err_o},   32'h0);
        cyc(1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("t5_perr_under", {31'h0, proto_err_o},  32'h1);
        cyc(1'b1, 32'hBEEF, 1'b0, 1'b0);
        check_eq("t5_cnt0_commit", {31'h0, update_pending_o}, 32'h1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0);
        check_eq("t5_tpr_beef", tpr_o, 32'hBEEF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_tpr_update_ctrl.md
# riscv_tpr_update_ctrl

Sequences software updates of the Tag Propagation Register (TPR) so that the store tag-enable decode in ID never sees the TPR change while a tagged store is still in flight. CSR writes to the TPR land in a shadow register. The committed TPR that drives the ID-stage enable decoder is updated only after every outstanding store has completed. Until then, new stores are held in ID. The block sits between the CSR file, the ID stage and the LSU.

## Interface
Parameters:
- OUTST_W, 2, width of the outstanding-store counter; at most 2**OUTST_W-1 stores in flight
- TPR_RST, 32'h0000_0000, reset value of committed and shadow TPR

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- tpr_we_i  in  1  single-cycle CSR write strobe for the TPR
- tpr_wdata_i  in  32  CSR write data
- is_store_id_i  in  1  store decoded in ID (from enable-tag decoder is_store)
- store_issue_i  in  1  store accepted into EX this cycle (id_valid & ex_ready & is_store)
- store_done_i  in  1  LSU completion (rvalid) for a store
- tpr_o  out  32  committed TPR, feeds the enable-tag decoder
- tpr_rdata_o  out  32  CSR read value: shadow if update pending, else committed
- stall_store_o  out  1  hold the store currently in ID
- update_pending_o  out  1  shadow differs from committed / FSM not IDLE
- proto_err_o  out  1  sticky protocol-violation flag

## Operation
- Counter cnt (OUTST_W bits):
  - +1 on store_issue_i only; -1 on store_done_i only; unchanged on both or neither.
  - cnt_next is the post-update value.
- FSM states IDLE, DRAIN, COMMIT:
  - IDLE:
    - tpr_we_i: shadow <= wdata.
    - Go to COMMIT if cnt_next==0, else go to DRAIN.
  - DRAIN:
    - tpr_we_i overwrites shadow (last write wins) and the FSM stays in DRAIN.
    - Go to COMMIT when cnt_next==0.
  - COMMIT:
    - At the closing edge, tpr_o <= (tpr_we_i ? tpr_wdata_i : shadow).
    - shadow takes the same value.
    - Go to IDLE.
- stall_store_o = is_store_id_i & ((state!=IDLE) | (cnt == 2**OUTST_W-1)). It is combinational and only asserted when a store is present in ID.
- update_pending_o = (state != IDLE).
- tpr_rdata_o = update_pending_o ? shadow : tpr_o.
- proto_err_o is set, and held until reset, by any of:
  - store_issue_i while stall_store_o was asserted (the issue is still counted, saturating at max);
  - store_done_i with cnt==0 (ignored, counter stays 0);
  - store_issue_i at cnt==max with no done (counter saturates).
- Non-store instructions are never stalled.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - state=IDLE, cnt=0;
  - tpr_o = shadow = TPR_RST;
  - stall_store_o=0 (given is_store_id_i), update_pending_o=0, proto_err_o=0.
- Reset asserted mid-DRAIN or mid-COMMIT discards the pending shadow value.
- Minimum update latency:
  - tpr_we_i at cycle N with cnt_next==0: COMMIT during N+1, new tpr_o visible from N+2.
  - tpr_rdata_o shows the new value from N+1.
- With stores in flight: COMMIT occurs in the cycle after the cycle whose store_done_i brings cnt_next to 0. tpr_o changes one cycle after that.
- A store issue and the last completion in the same cycle keep cnt unchanged, so DRAIN continues.
- stall_store_o is asserted from the cycle after tpr_we_i (state!=IDLE) through the COMMIT cycle inclusive. The store in ID issues at the earliest in the first IDLE cycle, decoding with the new tpr_o.
- A tpr_we_i in the COMMIT cycle is committed directly. There is no extra DRAIN because stores are blocked.

## Test plan
- Reset then idle write: tpr_we_i=1, wdata=32'h0000_0F00, cnt=0 at cycle 0. Required: tpr_rdata_o=0F00 at cycle 1, tpr_o=0F00 at cycle 2, update_pending_o high for cycle 1 only.
- Drain with two stores in flight: cnt=2, write 32'hA5A5_0000. Required: tpr_o holds its old value; stall_store_o=1 while is_store_id_i=1. Dones arrive at cycles 3 and 6; COMMIT in cycle 7; tpr_o=A5A5_0000 at cycle 8; stall drops in cycle 8.
- Back-to-back writes in DRAIN: writes of 1, 2 and 3 while cnt=1. Required: tpr_rdata_o tracks the last write; after done, tpr_o=3, and values 1 and 2 never appear on tpr_o.
- Simultaneous issue and done at cnt=1 during DRAIN: cnt stays 1 and the FSM stays in DRAIN; the next lone done triggers COMMIT. Issue while stalled: proto_err_o=1 and stays high.
- Saturation with OUTST_W=2: three issues leave cnt=3; a fourth store in ID gives stall_store_o=1. A done with cnt=0 sets proto_err_o and cnt stays 0.
- Reset mid-DRAIN: assert rst_n=0 asynchronously with shadow=32'h1234. Required: tpr_o=TPR_RST immediately, update_pending_o=0, the shadow value is never committed.
